// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Holds one decoded instruction and presents forwarded ALU operands.
module id_ex_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [3:0]      in_alu_ctrl,
  input  logic            in_alu_src,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_mem_to_reg,
  input  logic            in_branch,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic            out_branch,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [3:0]      r_alu_ctrl;
  logic            r_alu_src;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_mem_to_reg;
  logic            r_branch;

  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;

  // Pipeline entry: reset clears, flush bubbles, stall holds, else load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_ctrl   <= 4'b0000;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_alu_ctrl   <= 4'b0000;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else if (!stall) begin
      r_valid      <= in_valid;
      r_pc         <= in_pc;
      r_imm        <= in_imm;
      r_rs1_data   <= in_rs1_data;
      r_rs2_data   <= in_rs2_data;
      r_rs1        <= in_rs1;
      r_rs2        <= in_rs2;
      r_rd         <= in_rd;
      r_alu_ctrl   <= in_alu_ctrl;
      r_alu_src    <= in_alu_src;
      r_reg_write  <= in_valid & in_reg_write;
      r_mem_read   <= in_valid & in_mem_read;
      r_mem_write  <= in_valid & in_mem_write;
      r_mem_to_reg <= in_valid & in_mem_to_reg;
      r_branch     <= in_valid & in_branch;
    end
  end

  // Forward select: nearer EX/MEM result beats MEM/WB; x0 never bypassed.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r_rs1)
      w_fwd_a = 2'b10;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r_rs1)
      w_fwd_a = 2'b01;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r_rs2)
      w_fwd_b = 2'b10;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r_rs2)
      w_fwd_b = 2'b01;
  end

  // Operand muxes driven by the forward selects.
  always_comb begin
    w_op_a = r_rs1_data;
    w_op_b = r_rs2_data;
    unique case (w_fwd_a)
      2'b10:   w_op_a = exmem_result;
      2'b01:   w_op_a = memwb_result;
      default: w_op_a = r_rs1_data;
    endcase
    unique case (w_fwd_b)
      2'b10:   w_op_b = exmem_result;
      2'b01:   w_op_b = memwb_result;
      default: w_op_b = r_rs2_data;
    endcase
  end

  assign fwd_a          = w_fwd_a;
  assign fwd_b          = w_fwd_b;
  assign alu_a          = w_op_a;
  assign store_data     = w_op_b;
  assign alu_b          = r_alu_src ? r_imm : w_op_b;
  assign out_valid      = r_valid;
  assign alu_ctrl       = r_alu_ctrl;
  assign out_pc         = r_pc;
  assign out_imm        = r_imm;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_reg_write;
  assign out_mem_read   = r_mem_read;
  assign out_mem_write  = r_mem_write;
  assign out_mem_to_reg = r_mem_to_reg;
  assign out_branch     = r_branch;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed vector table, hand sequences,
// and randomized traffic against an instruction-level model.
module tb_id_ex_reg;

  logic        clk, rst, stall, flush;
  logic        in_valid;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_alu_ctrl;
  logic        in_alu_src, in_reg_write, in_mem_read;
  logic        in_mem_write, in_mem_to_reg, in_branch;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;

  logic        out_valid;
  logic [31:0] alu_a, alu_b, store_data, out_pc, out_imm;
  logic [3:0]  alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        out_mem_to_reg, out_branch;
  logic [1:0]  fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  id_ex_reg #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_alu_ctrl(in_alu_ctrl),
    .in_alu_src(in_alu_src), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_branch(in_branch),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .store_data(store_data),
    .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] ctl_out();
    return {out_reg_write, out_mem_read, out_mem_write,
            out_mem_to_reg, out_branch};
  endfunction

  task automatic drive_rand();
    stall          = ($urandom_range(0, 5) == 0);
    flush          = ($urandom_range(0, 7) == 0);
    in_valid       = ($urandom_range(0, 4) != 0);
    in_pc          = $urandom;
    in_rs1_data    = $urandom;
    in_rs2_data    = $urandom;
    in_imm         = $urandom;
    in_rs1         = 5'($urandom_range(0, 7));
    in_rs2         = 5'($urandom_range(0, 7));
    in_rd          = 5'($urandom_range(0, 31));
    in_alu_ctrl    = 4'($urandom_range(0, 8));
    in_alu_src     = 1'($urandom);
    in_reg_write   = 1'($urandom);
    in_mem_read    = 1'($urandom);
    in_mem_write   = 1'($urandom);
    in_mem_to_reg  = 1'($urandom);
    in_branch      = 1'($urandom);
    exmem_reg_write = 1'($urandom);
    exmem_rd        = 5'($urandom_range(0, 7));
    exmem_result    = $urandom;
    memwb_reg_write = 1'($urandom);
    memwb_rd        = 5'($urandom_range(0, 7));
    memwb_result    = $urandom;
  endtask

  // Instruction-level model of the single execute slot.
  typedef struct packed {
    logic        v;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic        src;
    logic [4:0]  cb;
  } mdl_t;
  mdl_t m;

  // Value a source register sees: youngest in-flight writer, else regfile.
  function automatic logic [33:0] pick(logic [4:0] r, logic [31:0] rf);
    if (r == 0) return {2'b00, rf};
    if (exmem_reg_write && exmem_rd == r) return {2'b10, exmem_result};
    if (memwb_reg_write && memwb_rd == r) return {2'b01, memwb_result};
    return {2'b00, rf};
  endfunction

  task automatic model_step();
    if (flush) begin
      m.v = 0;
      m.cb = 0;
      m.ctrl = 0;
    end else if (!stall) begin
      m.v = in_valid;
      m.pc = in_pc;
      m.imm = in_imm;
      m.d1 = in_rs1_data;
      m.d2 = in_rs2_data;
      m.rs1 = in_rs1;
      m.rs2 = in_rs2;
      m.rd = in_rd;
      m.ctrl = in_alu_ctrl;
      m.src = in_alu_src;
      m.cb = in_valid ? {in_reg_write, in_mem_read, in_mem_write,
                         in_mem_to_reg, in_branch} : 5'd0;
    end
  endtask

  task automatic model_check(string tag);
    logic [33:0] a, b;
    a = pick(m.rs1, m.d1);
    b = pick(m.rs2, m.d2);
    chk({tag, "_valid"}, 32'(out_valid), 32'(m.v));
    chk({tag, "_ctl"}, 32'(ctl_out()), 32'(m.cb));
    if (m.v) begin
      chk({tag, "_alu_a"}, alu_a, a[31:0]);
      chk({tag, "_fwd_a"}, 32'(fwd_a), 32'(a[33:32]));
      chk({tag, "_sdata"}, store_data, b[31:0]);
      chk({tag, "_fwd_b"}, 32'(fwd_b), 32'(b[33:32]));
      chk({tag, "_alu_b"}, alu_b, m.src ? m.imm : b[31:0]);
      chk({tag, "_aluctl"}, 32'(alu_ctrl), 32'(m.ctrl));
      chk({tag, "_pc"}, out_pc, m.pc);
      chk({tag, "_imm"}, out_imm, m.imm);
      chk({tag, "_rd"}, 32'(out_rd), 32'(m.rd));
    end
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic        src, rw;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] eres;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic [31:0] xa, xb, xsd;
    logic [1:0]  xfa, xfb;
    logic        xval, xrw;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 5, 7, 0, 1, 2, 3, 0, 0, 1,
              0, 0, 0, 0, 0, 0, 5, 7, 7, 0, 0, 1, 1};
    vt[1] = '{1, 9, 3, 32'hFFFF_FFF0, 1, 2, 3, 0, 1, 1,
              0, 0, 0, 0, 0, 0,
              9, 32'hFFFF_FFF0, 3, 0, 0, 1, 1};
    vt[2] = '{1, 1, 2, 0, 4, 6, 7, 2, 0, 1,
              1, 4, 32'h11, 1, 4, 32'h22,
              32'h11, 2, 2, 2'b10, 0, 1, 1};
    vt[3] = '{1, 1, 2, 0, 4, 6, 7, 2, 0, 1,
              0, 4, 32'h11, 1, 4, 32'h22,
              32'h22, 2, 2, 2'b01, 0, 1, 1};
    vt[4] = '{1, 8, 0, 0, 3, 0, 9, 0, 0, 1,
              1, 0, 32'hDEAD, 0, 0, 0,
              8, 0, 0, 0, 0, 1, 1};
    vt[5] = '{0, 1, 1, 0, 1, 1, 2, 0, 0, 1,
              0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    vt[6] = '{1, 10, 20, 0, 7, 5, 1, 3, 0, 1,
              1, 6, 32'h33, 1, 5, 32'h44,
              10, 32'h44, 32'h44, 0, 2'b01, 1, 1};
    vt[7] = '{1, 10, 20, 100, 5, 5, 2, 4, 1, 0,
              1, 5, 32'h55, 1, 5, 32'h66,
              32'h55, 100, 32'h55, 2'b10, 2'b10, 1, 0};

    rst = 0;
    drive_rand();
    stall = 0;
    flush = 0;
    #1 rst = 1;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_aluctl", 32'(alu_ctrl), 0);
    chk("rst_ctl", 32'(ctl_out()), 0);
    chk("rst_rd", 32'(out_rd), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_imm", out_imm, 0);
    @(negedge clk);
    rst = 0;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      in_valid = vt[i].vld;
      in_pc = 32'h100 + 32'(i * 4);
      in_rs1_data = vt[i].d1;
      in_rs2_data = vt[i].d2;
      in_imm = vt[i].imm;
      in_rs1 = vt[i].rs1;
      in_rs2 = vt[i].rs2;
      in_rd = vt[i].rd;
      in_alu_ctrl = vt[i].ctrl;
      in_alu_src = vt[i].src;
      in_reg_write = vt[i].rw;
      in_mem_read = 0;
      in_mem_write = 0;
      in_mem_to_reg = 0;
      in_branch = 0;
      exmem_reg_write = vt[i].ewe;
      exmem_rd = vt[i].erd;
      exmem_result = vt[i].eres;
      memwb_reg_write = vt[i].mwe;
      memwb_rd = vt[i].mrd;
      memwb_result = vt[i].mres;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vt[i].xval));
      chk($sformatf("v%0d_rw", i), 32'(out_reg_write), 32'(vt[i].xrw));
      chk($sformatf("v%0d_alu_a", i), alu_a, vt[i].xa);
      chk($sformatf("v%0d_alu_b", i), alu_b, vt[i].xb);
      chk($sformatf("v%0d_sdata", i), store_data, vt[i].xsd);
      chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(vt[i].xfa));
      chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(vt[i].xfb));
      if (vt[i].vld)
        chk($sformatf("v%0d_aluctl", i), 32'(alu_ctrl), 32'(vt[i].ctrl));
      @(negedge clk);
    end

    // Load SUB, then hold it through three stalled cycles
    in_valid = 1;
    in_pc = 32'h200;
    in_rs1_data = 50;
    in_rs2_data = 8;
    in_imm = 0;
    in_rs1 = 0;
    in_rs2 = 0;
    in_rd = 9;
    in_alu_ctrl = 4'b0001;
    in_alu_src = 0;
    in_reg_write = 1;
    in_mem_write = 1;
    in_mem_read = 0;
    in_mem_to_reg = 0;
    in_branch = 0;
    exmem_reg_write = 0;
    memwb_reg_write = 0;
    @(posedge clk);
    #1;
    chk("sub_aluctl", 32'(alu_ctrl), 1);
    chk("sub_valid", 32'(out_valid), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_rand();
      stall = 1;
      flush = 0;
      exmem_reg_write = 0;
      memwb_reg_write = 0;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_aluctl", k), 32'(alu_ctrl), 1);
      chk($sformatf("stall%0d_pc", k), out_pc, 32'h200);
      chk($sformatf("stall%0d_rd", k), 32'(out_rd), 9);
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("stall%0d_alu_a", k), alu_a, 50);
      chk($sformatf("stall%0d_ctl", k), 32'(ctl_out()), 5'b10100);
    end
    @(negedge clk);
    stall = 1;
    flush = 1;
    @(posedge clk);
    #1;
    chk("sflush_valid", 32'(out_valid), 0);
    chk("sflush_rw", 32'(out_reg_write), 0);
    chk("sflush_mw", 32'(out_mem_write), 0);
    chk("sflush_aluctl", 32'(alu_ctrl), 0);

    // Reset in mid-cycle clears the entry without a clock edge
    @(negedge clk);
    stall = 0;
    flush = 0;
    in_valid = 1;
    in_reg_write = 1;
    in_alu_ctrl = 4'b0101;
    in_pc = 32'h300;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_pc", out_pc, 0);
    chk("async_rst_aluctl", 32'(alu_ctrl), 0);
    chk("async_rst_rw", 32'(out_reg_write), 0);
    m = '0;
    @(negedge clk);
    rst = 0;

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive_rand();
      model_step();
      @(posedge clk);
      #1;
      model_check("rnd");
      exmem_reg_write = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom);
      memwb_rd = 5'($urandom_range(0, 7));
      memwb_result = $urandom;
      #1;
      model_check("byp");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
